// File: rtl/coeff_collector.sv
// Reassembles DCT_POINT serial float coefficients into one parallel frame with a non-zero count.
// Latency: frame visible the cycle after its last beat is sampled; one frame can wait in the collect buffer.
// Backpressure: out_valid/out_ready handshake; beats arriving while both levels are full are dropped with overflow.
module coeff_collector #(
   parameter int DCT_POINT = 16,
   parameter int M         = 23,
   parameter int E         = 8,
   parameter int K         = 6,
   localparam int W        = M + E + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic                   frame_start,
   input  logic [W-1:0]           inp,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [W*DCT_POINT-1:0] frame,
   output logic [K-1:0]           nz_count,
   output logic                   sync_err,
   output logic                   overflow
);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t                 state, state_nx;
   logic [W*DCT_POINT-1:0] cbuf, cbuf_nx;
   logic [K-1:0]           idx, idx_nx;
   logic [K-1:0]           cnt, cnt_nx;
   logic [K-1:0]           wr_slot;
   logic                   buf_we, load_out, sync_nx, ovf_nx;
   logic                   nz_in, slot_free, last_beat;

   // Zero, -0 and denormals all have a zero exponent field.
   assign nz_in     = |inp[M+E-1:M];
   // Output register can take a new frame on this edge.
   assign slot_free = !out_valid || out_ready;
   assign last_beat = (idx == K'(DCT_POINT - 1));

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state decision.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid && frame_start) state_nx = COLLECT;
         COLLECT: if (in_valid && !frame_start && last_beat)
                     state_nx = slot_free ? IDLE : HOLD;
         HOLD:    if (out_valid && out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Per-state datapath controls: buffer write, index/count update, output load, error pulses.
   always_comb begin
      idx_nx   = idx;
      cnt_nx   = cnt;
      wr_slot  = idx;
      buf_we   = 1'b0;
      load_out = 1'b0;
      sync_nx  = 1'b0;
      ovf_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (frame_start) begin
                  buf_we  = 1'b1;
                  wr_slot = '0;
                  idx_nx  = K'(1);
                  cnt_nx  = K'(nz_in);
               end else begin
                  sync_nx = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (in_valid) begin
               if (frame_start) begin
                  // Partial frame abandoned; this beat becomes slot 0 of a fresh frame.
                  sync_nx = 1'b1;
                  buf_we  = 1'b1;
                  wr_slot = '0;
                  idx_nx  = K'(1);
                  cnt_nx  = K'(nz_in);
               end else begin
                  buf_we = 1'b1;
                  idx_nx = idx + K'(1);
                  cnt_nx = cnt + K'(nz_in);
                  if (last_beat && slot_free) begin
                     load_out = 1'b1;
                     idx_nx   = '0;
                  end
               end
            end
         end
         HOLD: begin
            ovf_nx = in_valid;
            if (out_valid && out_ready) begin
               load_out = 1'b1;
               idx_nx   = '0;
            end
         end
         default: ;
      endcase
   end

   // Collect buffer with the current beat merged in, so a completing frame can go straight out.
   always_comb begin
      cbuf_nx = cbuf;
      for (int i = 0; i < DCT_POINT; i++) begin
         if (buf_we && wr_slot == K'(i)) cbuf_nx[i*W +: W] = inp;
      end
   end

   // Collect buffer storage; contents are always rewritten before they are used.
   always_ff @(posedge clk) begin
      cbuf <= cbuf_nx;
   end

   // Index, running count, output register and registered error pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         frame     <= '0;
         nz_count  <= '0;
         sync_err  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         idx      <= idx_nx;
         cnt      <= cnt_nx;
         sync_err <= sync_nx;
         overflow <= ovf_nx;
         if (load_out) begin
            frame     <= cbuf_nx;
            nz_count  <= cnt_nx;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/coeff_collector.md
# coeff_collector

Receive-side counterpart to the DCT engine's serial coefficient output. Accepts one 32-bit float coefficient per valid beat and reassembles a frame of DCT_POINT coefficients into one parallel word. Counts non-zero coefficients per frame and presents the frame through a valid/ready handshake. Frames can therefore be handed to a downstream quantiser or packer without stalling the engine more than one frame deep.

## Interface

- DCT_POINT, 16, coefficients per frame (≥2)
- M, 23, mantissa width
- E, 8, exponent width; word width W = M+E+1
- K, 6, width of index and nz_count; must satisfy 2^K > DCT_POINT
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  beat present on inp
- frame_start  input  1  qualifies beat as coefficient 0 of a frame (ignored without in_valid)
- inp  input  W  coefficient, IEEE-style {sign, exponent[E], mantissa[M]}
- out_ready  input  1  downstream accepts frame
- out_valid  output  1  frame/nz_count valid
- frame  output  W*DCT_POINT  coefficient i at bits [W*(i+1)-1 : W*i]
- nz_count  output  K  number of coefficients in frame with exponent field ≠ 0
- sync_err  output  1  one-cycle pulse: framing violation
- overflow  output  1  one-cycle pulse: beat dropped, buffers full

## Operation

- Two storage levels: collect buffer (DCT_POINT words + running nz count + index) and output register (frame, nz_count, out_valid).
- Non-zero test: exponent field inp[M+E-1:M] ≠ 0. Denormals and ±0 count as zero. nz_count reaches DCT_POINT at most.
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - in_valid & frame_start: store at slot 0, idx=1, running count = nz(inp), go COLLECT.
  - in_valid & !frame_start: beat discarded, sync_err pulse, stay IDLE.
- COLLECT:
  - in_valid & frame_start: partial frame discarded, sync_err pulse, restart at slot 0 as in IDLE.
  - in_valid & !frame_start: store at slot idx, idx+1, count += nz(inp).
  - When the stored beat is slot DCT_POINT-1, the frame is complete.
    - If the output slot is free this cycle (out_valid=0, or out_valid&out_ready), transfer the full frame, including this beat and final count, to the output register on the same edge. Set out_valid=1, go IDLE, idx=0.
    - Otherwise go HOLD.
  - With DCT_POINT=1, a frame_start beat completes the frame immediately. This configuration is not required to be supported; DCT_POINT ≥ 2.
- HOLD:
  - Every in_valid beat is dropped with an overflow pulse, including on the release cycle.
  - On out_valid & out_ready, transfer the collect buffer to the output register; out_valid stays 1; go IDLE.
- Output handshake:
  - While out_valid=1 and out_ready=0, frame and nz_count hold stable.
  - On acceptance with no transfer on the same edge, out_valid falls next edge. frame/nz_count keep their last value.
- Reset (any time, async): state IDLE, idx 0, count 0, out_valid 0, frame 0, nz_count 0, sync_err 0, overflow 0. A partial frame is discarded. Collect buffer contents need not be cleared.

## Timing

- Beats sampled on rising clk edge when in_valid=1.
- Latency: last beat sampled at edge t gives out_valid=1 after edge t when the slot is free. Back-to-back frames are sustained at one beat per cycle when out_ready=1.
- Accept at edge t with a new frame completing at edge t: out_valid stays 1, new data visible after t, no bubble.
- sync_err/overflow are registered, high for exactly the cycle after the offending edge.
- Frame-to-frame throughput with out_ready held 0: exactly two frames are buffered (output register + HOLD). The third frame's beats all raise overflow.
- No combinational path from in_valid/inp to outputs. out_ready affects only next-state.

## Test plan

- 16 beats of 0x3F800000, frame_start on beat 0, out_ready=1 → out_valid high exactly one cycle after last edge; every frame slot is 0x3F800000; nz_count=16.
- Frame: beat 0=0x40000000, beat 1=0x80000000, beat 2=0x00000001, rest 0x00000000 → nz_count=1; slot 1 reads 0x80000000.
- out_ready=0; send frame A (all 0x3F800000) then frame B (all 0xC0000000) back-to-back; then 16 more beats → 16 overflow pulses. Raise out_ready → A accepted, B appears next cycle with out_valid continuous; dropped beats never appear.
- frame_start reasserted on beat 5, then 15 more beats → one sync_err pulse; output frame equals the 16 beats starting at the restart.
- 3 beats with in_valid=1, frame_start=0 after reset → 3 sync_err pulses, out_valid stays 0.
- reset asserted after beat 8, released, full frame sent → all outputs 0 during reset; the following frame is complete and correct, with nz_count matching only the new frame.
